rom_fetch_reader: RTL and testbench

Fetch-side reader for the team's asynchronous, parameterized read-only memory: drives the memory's address, output-enable and active-low chip-select, samples its data bus after a configurable number of wait cycles, and buffers fetched words with their addresses in a small show-ahead prefetch FIFO. Sits between the instruction ROM and the RISCY decode stage. The ROM side needs no handshake. The decode side uses a valid/ready handshake.

---
 rtl/rom_fetch_pkg.sv | 29 ++
 rtl/rom_fetch_fifo.sv | 78 +++++++
 rtl/rom_fetch_reader.sv | 154 +++++++++++++++
 tb/tb_rom_fetch_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_pkg.sv
// ---------------------------------------------------------------------------
// rom_fetch_pkg
// Shared types and constants for the ROM fetch reader.
//   state_t        : fetch FSM states (TURN is only reachable when the
//                    ROM_FETCH_TURNAROUND_EN macro is defined)
//   fetch_entry_t  : prefetch FIFO entry (fetched word + its address) at the
//                    default widths; the reader builds the same layout from
//                    its own parameters
//   WAIT_W         : width of the access wait counter (WAIT_CYCLES 0..15)
// ---------------------------------------------------------------------------
package rom_fetch_pkg;

    localparam int WIDTH_DEF      = 8;
    localparam int DEPTH_DEF      = 5;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int WAIT_W         = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] word;
        logic [DEPTH_DEF-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/rom_fetch_fifo.sv
// ---------------------------------------------------------------------------
// rom_fetch_fifo
// Synchronous show-ahead FIFO holding prefetched words with their addresses.
// The head entry is visible on rd_data whenever empty is low; rd_en pops it.
// flush empties the FIFO and wins over a same-cycle write or pop.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : discard all entries
//   wr_en      : push wr_data
//   wr_data    : entry to push
//   rd_en      : pop the head entry
//   rd_data    : head entry (combinational)
//   count      : number of stored entries
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module rom_fetch_fifo
    import rom_fetch_pkg::*;
#(
    parameter type entry_t    = fetch_entry_t,
    parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  entry_t           wr_data,
    input  logic             rd_en,
    output entry_t           rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is reset too so the head word reads as zero after
            // reset; this only works because the FIFO is a few flops deep.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_fetch_reader.sv
// ---------------------------------------------------------------------------
// rom_fetch_reader
// Fetches words from an asynchronous ROM and queues them, with their
// addresses, in a show-ahead prefetch FIFO for the decode stage.
// Configuration macro: ROM_FETCH_TURNAROUND_EN -- when defined, one TURN
// cycle with the chip deselected follows every capture.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : fetch enable
//   start       : one-cycle pulse: flush FIFO, abort access, pc <= start_addr
//   start_addr  : new fetch address
//   rom_addr    : memory address (always the fetch pc)
//   rom_oe      : memory output enable, active-high
//   rom_cs      : memory chip select, active-low
//   rom_data    : memory data bus
//   instr       : word at the FIFO head
//   instr_addr  : address of the FIFO head word
//   valid       : FIFO non-empty
//   ready       : consumer takes the head word when valid is high
// ---------------------------------------------------------------------------
module rom_fetch_reader
    import rom_fetch_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = 1,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [DEPTH-1:0] start_addr,
    output logic [DEPTH-1:0] rom_addr,
    output logic             rom_oe,
    output logic             rom_cs,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] instr,
    output logic [DEPTH-1:0] instr_addr,
    output logic             valid,
    input  logic             ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic [DEPTH-1:0] addr;
    } entry_t;

    state_t            state;
    logic [DEPTH-1:0]  pc;
    logic [WAIT_W-1:0] wait_cnt;
    logic              pop;
    logic              capture;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    entry_t            wr_entry;
    entry_t            head;

    assign rom_addr   = pc;
    assign valid      = !fifo_empty;
    assign pop        = valid && ready;
    assign instr      = head.word;
    assign instr_addr = head.addr;

    // START aborts the access, so the word on the bus is never captured.
    assign capture  = (state == ACCESS) && (wait_cnt == '0) && !start;
    assign wr_entry = '{word: rom_data, addr: pc};

`ifndef ROM_FETCH_TURNAROUND_EN
    // Occupancy after this cycle's capture and pop decides whether the next
    // access can start right away with CS held low.
    logic [CNT_W-1:0] next_count;
    logic             keep_fetching;

    assign next_count    = fifo_count + CNT_W'(1) - CNT_W'(pop);
    assign keep_fetching = en && (next_count < CNT_W'(FIFO_DEPTH));
`endif

    // NOTE: state, pc, counter and the CS/OE pins live in one clocked block
    // with non-blocking assignments, so every output is a clean flop and the
    // async reset deselects the ROM immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            wait_cnt <= '0;
            rom_cs   <= 1'b1;
            rom_oe   <= 1'b0;
        end else if (start) begin
            state    <= IDLE;
            pc       <= start_addr;
            wait_cnt <= '0;
            rom_cs   <= 1'b1;
            rom_oe   <= 1'b0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (en && !fifo_full) begin
                        state    <= ACCESS;
                        wait_cnt <= WAIT_W'(WAIT_CYCLES);
                        rom_cs   <= 1'b0;
                        rom_oe   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        pc <= pc + 1'b1;
`ifdef ROM_FETCH_TURNAROUND_EN
                        state  <= TURN;
                        rom_cs <= 1'b1;
                        rom_oe <= 1'b0;
`else
                        if (keep_fetching) begin
                            wait_cnt <= WAIT_W'(WAIT_CYCLES);
                        end else begin
                            state  <= IDLE;
                            rom_cs <= 1'b1;
                            rom_oe <= 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    rom_cs <= 1'b1;
                    rom_oe <= 1'b0;
                end
            endcase
        end
    end

    rom_fetch_fifo #(
        .entry_t    (entry_t),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (start),
        .wr_en   (capture),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_rom_fetch_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_fetch_reader
// Directed bench for rom_fetch_reader at WIDTH=8, DEPTH=5, WAIT_CYCLES=1,
// FIFO_DEPTH=4. The ROM holds 8'hA0 + address at every location.
// ---------------------------------------------------------------------------
module tb_rom_fetch_reader;

`ifdef ROM_FETCH_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif
    // cycles per word in steady state
    localparam int PERIOD = TURN_EN ? 3 : 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic [4:0] start_addr = '0;
    logic [4:0] rom_addr;
    logic       rom_oe;
    logic       rom_cs;
    wire  [7:0] rom_data;
    logic [7:0] instr;
    logic [4:0] instr_addr;
    logic       valid;

    logic [7:0] rom_mem [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Asynchronous ROM: drives the bus only while selected and enabled.
    assign rom_data = (!rom_cs && rom_oe) ? rom_mem[rom_addr] : 8'hzz;

    rom_fetch_reader #(
        .WIDTH       (8),
        .DEPTH       (5),
        .WAIT_CYCLES (1),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .start_addr (start_addr),
        .rom_addr   (rom_addr),
        .rom_oe     (rom_oe),
        .rom_cs     (rom_cs),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_addr (instr_addr),
        .valid      (valid),
        .ready      (ready)
    );

    function automatic logic [7:0] rom_word(input int a);
        return 8'(8'hA0 + a);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        en    = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL reset_rom_cs got %b want 1", rom_cs); end
        checks++; if (rom_oe !== 1'b0) begin errors++; $display("FAIL reset_rom_oe got %b want 0", rom_oe); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (instr !== 8'h00) begin errors++; $display("FAIL reset_instr got %h want 00", instr); end
        checks++; if (instr_addr !== 5'd0) begin errors++; $display("FAIL reset_instr_addr got %0d want 0", instr_addr); end
        rst = 1'b0;
    endtask

    // EN high from reset with READY=1: first capture at edge 3, then one
    // capture every PERIOD edges; each word is popped the cycle it shows.
    task automatic test_stream();
        int  n;
        bit  exp_valid;
        bit  exp_cs;
        do_reset();
        en    = 1'b1;
        ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n         = (k >= 3) ? (k - 3) / PERIOD + 1 : 0;
            exp_valid = (k >= 3) && ((k - 3) % PERIOD == 0);
            exp_cs    = TURN_EN && exp_valid;
            checks++; if (rom_addr !== 5'(n)) begin errors++; $display("FAIL stream_rom_addr cyc %0d got %0d want %0d", k, rom_addr, n); end
            checks++; if (rom_cs !== exp_cs) begin errors++; $display("FAIL stream_rom_cs cyc %0d got %b want %b", k, rom_cs, exp_cs); end
            checks++; if (rom_oe !== !exp_cs) begin errors++; $display("FAIL stream_rom_oe cyc %0d got %b want %b", k, rom_oe, !exp_cs); end
            checks++; if (valid !== exp_valid) begin errors++; $display("FAIL stream_valid cyc %0d got %b want %b", k, valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (instr_addr !== 5'(n - 1)) begin errors++; $display("FAIL stream_instr_addr cyc %0d got %0d want %0d", k, instr_addr, n - 1); end
                checks++; if (instr !== rom_word(n - 1)) begin errors++; $display("FAIL stream_instr cyc %0d got %h want %h", k, instr, rom_word(n - 1)); end
            end
        end
        en    = 1'b0;
        ready = 1'b0;
    endtask

    // READY=0: four captures fill the FIFO and the reader idles; one pop lets
    // exactly one more access run, at address 4.
    task automatic test_full();
        do_reset();
        en = 1'b1;
        repeat (16) @(negedge clk);
        checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL full_idle_cs got %b want 1", rom_cs); end
        checks++; if (rom_oe !== 1'b0) begin errors++; $display("FAIL full_idle_oe got %b want 0", rom_oe); end
        checks++; if (rom_addr !== 5'd4) begin errors++; $display("FAIL full_pc got %0d want 4", rom_addr); end
        checks++; if (valid !== 1'b1 || instr_addr !== 5'd0 || instr !== 8'hA0) begin
            errors++; $display("FAIL full_head got v=%b %0d/%h want v=1 0/a0", valid, instr_addr, instr); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++; if (instr_addr !== 5'd1) begin errors++; $display("FAIL full_pop_head got %0d want 1", instr_addr); end
        @(negedge clk);
        checks++; if (rom_cs !== 1'b0 || rom_addr !== 5'd4) begin
            errors++; $display("FAIL full_refetch got cs=%b addr=%0d want cs=0 addr=4", rom_cs, rom_addr); end
        en = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (rom_cs !== 1'b1 || rom_addr !== 5'd5) begin
            errors++; $display("FAIL full_after got cs=%b addr=%0d want cs=1 addr=5", rom_cs, rom_addr); end
        ready = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            checks++; if (valid !== 1'b1 || instr_addr !== 5'(a) || instr !== rom_word(a)) begin
                errors++; $display("FAIL full_drain got v=%b %0d/%h want v=1 %0d/%h", valid, instr_addr, instr, a, rom_word(a)); end
            @(negedge clk);
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL full_drained_valid got %b want 0", valid); end
        ready = 1'b0;
    endtask

    // PC wraps from 31 to 0.
    task automatic test_wrap();
        logic [4:0] exp_a [3];
        int got;
        exp_a = '{5'd30, 5'd31, 5'd0};
        got   = 0;
        do_reset();
        start_addr = 5'd30;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en    = 1'b1;
        ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            @(negedge clk);
            if (valid) begin
                checks++; if (instr_addr !== exp_a[got] || instr !== rom_word(int'(exp_a[got]))) begin
                    errors++; $display("FAIL wrap_word %0d got %0d/%h want %0d/%h", got, instr_addr, instr, exp_a[got], rom_word(int'(exp_a[got]))); end
                got++;
            end
        end
        checks++; if (got != 3) begin errors++; $display("FAIL wrap_timeout got %0d words want 3", got); end
        en    = 1'b0;
        ready = 1'b0;
    endtask

    // START mid-access at address 2 with words 31, 0, 1 queued.
    task automatic test_start_abort();
        bit found;
        int got;
        found = 1'b0;
        do_reset();
        start_addr = 5'd31;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en    = 1'b1;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            @(negedge clk);
            if (rom_addr == 5'd2 && rom_cs == 1'b0) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach_addr2 got addr=%0d cs=%b want addr=2 cs=0", rom_addr, rom_cs); end
        checks++; if (valid !== 1'b1 || instr_addr !== 5'd31) begin
            errors++; $display("FAIL abort_queue_head got v=%b %0d want v=1 31", valid, instr_addr); end
        @(negedge clk);
        checks++; if (rom_cs !== 1'b0 || rom_addr !== 5'd2) begin
            errors++; $display("FAIL abort_mid_access got cs=%b addr=%0d want cs=0 addr=2", rom_cs, rom_addr); end
        start_addr = 5'h10;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_flush_valid got %b want 0", valid); end
        checks++; if (rom_cs !== 1'b1 || rom_addr !== 5'h10) begin
            errors++; $display("FAIL abort_new_pc got cs=%b addr=%0d want cs=1 addr=16", rom_cs, rom_addr); end
        @(negedge clk);
        checks++; if (rom_cs !== 1'b0 || rom_addr !== 5'h10) begin
            errors++; $display("FAIL abort_next_access got cs=%b addr=%0d want cs=0 addr=16", rom_cs, rom_addr); end
        got = 0;
        for (int cyc = 0; cyc < 20 && got == 0; cyc++) begin
            @(negedge clk);
            if (valid) got = 1;
        end
        checks++; if (got != 1 || instr_addr !== 5'h10 || instr !== 8'hB0) begin
            errors++; $display("FAIL abort_first_word got v=%0d %0d/%h want 16/b0", got, instr_addr, instr); end
        en    = 1'b0;
        ready = 1'b0;
    endtask

    // EN dropped during the wait cycle: the word still lands, then no access.
    task automatic test_en_drop();
        int lows;
        lows = 0;
        do_reset();
        en    = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL endrop_access_cs got %b want 0", rom_cs); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL endrop_wait_cs got %b want 0", rom_cs); end
        @(negedge clk);
        checks++; if (valid !== 1'b1 || instr_addr !== 5'd0 || instr !== 8'hA0) begin
            errors++; $display("FAIL endrop_capture got v=%b %0d/%h want v=1 0/a0", valid, instr_addr, instr); end
        checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL endrop_cs_after got %b want 1", rom_cs); end
        repeat (8) begin
            @(negedge clk);
            if (!rom_cs) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL endrop_no_access got %0d cs-low cycles want 0", lows); end
        ready = 1'b0;
    endtask

    // Reset mid-access deselects the ROM at once and keeps no partial word.
    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        @(negedge clk);
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL rstmid_access_cs got %b want 0", rom_cs); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rom_cs !== 1'b1 || rom_oe !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got cs=%b oe=%b want cs=1 oe=0", rom_cs, rom_oe); end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (valid !== 1'b0 || rom_addr !== 5'd0) begin
            errors++; $display("FAIL rstmid_no_word got v=%b addr=%0d want v=0 addr=0", valid, rom_addr); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = rom_word(i);
        test_reset();
        test_stream();
        test_full();
        test_wrap();
        test_start_abort();
        test_en_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
